// File: rtl/load_store_unit.sv
// load_store_unit
//
// Bridges the single-cycle core's data-memory port to a handshaked data bus.
// The core's access (address, write data, funct3, memRead/memWrite) becomes one
// bus transaction with byte strobes. Load data returns sign- or zero-extended.
// The core is stalled until the access completes. Misaligned accesses, bus
// errors and bus timeouts are flagged.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   memRead, memWrite        core access request (memWrite wins if both set)
//   funct3                   access size / signedness
//   address, writeData       byte address and right-aligned store data
//   readData                 extended load data, valid in DONE
//   stall                    core must hold PC and inputs
//   misaligned               combinational alignment fault; no bus access made
//   busError                 one-cycle pulse on bus error or timeout
//   busReq/busWe/busAddr/busWdata/busStrb   registered bus request
//   busAck/busRdata/busErr   bus response
//
// Optional feature macro: LSU_STORE_BUFFER_EN
//   When defined, an aligned store seen in IDLE is captured without stalling
//   and drains over the bus in the background. Any access arriving during the
//   drain waits for the drain's busAck. Drain errors pulse busError one cycle
//   after the drain completes.
//
// state | meaning
// IDLE  | waiting for an access; decode alignment, launch the bus request
// REQ   | busReq held until busAck or timeout
// DONE  | result presented for one cycle; the core advances

module load_store_unit #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            memRead,
    input  logic            memWrite,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] address,
    input  logic [XLEN-1:0] writeData,
    output logic [XLEN-1:0] readData,
    output logic            stall,
    output logic            misaligned,
    output logic            busError,
    output logic            busReq,
    output logic            busWe,
    output logic [XLEN-1:0] busAddr,
    output logic [XLEN-1:0] busWdata,
    output logic [3:0]      busStrb,
    input  logic            busAck,
    input  logic [XLEN-1:0] busRdata,
    input  logic            busErr
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              busReq_q, busWe_q, busError_q;
    logic [XLEN-1:0]   busAddr_q, busWdata_q, readData_q;
    logic [3:0]        busStrb_q;
    logic [2:0]        f3_q;
    logic [1:0]        lane_q;

    logic              access, is_byte, is_half, aligned;
    logic [3:0]        strb_n;
    logic [XLEN-1:0]   wdata_n;
    logic [15:0]       lane_data;
    logic [XLEN-1:0]   load_ext;
    logic              start, req_end, end_err, stall_c, mis_c;
    logic              draining, buffer_store;

`ifdef LSU_STORE_BUFFER_EN
    logic drain_q;

    // In IDLE the buffer is always empty, so every aligned store is buffered.
    assign draining     = drain_q;
    assign buffer_store = memWrite;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_q <= 1'b0;
        end else if (start) begin
            drain_q <= memWrite;
        end
    end
`else
    assign draining     = 1'b0;
    assign buffer_store = 1'b0;
`endif

    // Access decode: funct3[1:0] picks the size; 011/11x fall through to word.
    always_comb begin
        access  = memRead | memWrite;
        is_byte = (funct3[1:0] == 2'b00);
        is_half = (funct3[1:0] == 2'b01);
        if (is_byte) begin
            aligned = 1'b1;
        end else if (is_half) begin
            aligned = ~address[0];
        end else begin
            aligned = (address[1:0] == 2'b00);
        end

        strb_n  = 4'b0000;
        wdata_n = '0;
        if (memWrite) begin
            if (is_byte) begin
                strb_n  = 4'b0001 << address[1:0];
                wdata_n = {4{writeData[7:0]}};
            end else if (is_half) begin
                strb_n  = address[1] ? 4'b1100 : 4'b0011;
                wdata_n = {2{writeData[15:0]}};
            end else begin
                strb_n  = 4'b1111;
                wdata_n = writeData;
            end
        end
    end

    // Load extraction uses the size/lane latched at launch, not live inputs.
    always_comb begin
        lane_data = 16'(busRdata >> {lane_q, 3'b000});
        case (f3_q)
            3'b000:  load_ext = {{24{lane_data[7]}}, lane_data[7:0]};
            3'b001:  load_ext = {{16{lane_data[15]}}, lane_data[15:0]};
            3'b100:  load_ext = {24'b0, lane_data[7:0]};
            3'b101:  load_ext = {16'b0, lane_data[15:0]};
            default: load_ext = busRdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        req_end = 1'b0;
        end_err = 1'b0;
        stall_c = 1'b0;
        mis_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (access) begin
                    if (aligned) begin
                        start   = 1'b1;
                        state_d = S_REQ;
                        stall_c = ~buffer_store;
                    end else begin
                        mis_c = 1'b1;
                    end
                end
            end
            S_REQ: begin
                // A background drain only holds the core if it wants the bus.
                stall_c = draining ? access : 1'b1;
                // Ack is checked first so an ack on the expiry cycle wins.
                if (busAck) begin
                    req_end = 1'b1;
                    end_err = busErr;
                end else if (cnt_q == CNT_LAST) begin
                    req_end = 1'b1;
                    end_err = 1'b1;
                end
                if (req_end) begin
                    state_d = draining ? S_IDLE : S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            busReq_q   <= 1'b0;
            busWe_q    <= 1'b0;
            busAddr_q  <= '0;
            busWdata_q <= '0;
            busStrb_q  <= 4'b0000;
            readData_q <= '0;
            busError_q <= 1'b0;
            f3_q       <= 3'b000;
            lane_q     <= 2'b00;
        end else begin
            busError_q <= req_end & end_err;
            if (start) begin
                busReq_q   <= 1'b1;
                busWe_q    <= memWrite;
                busAddr_q  <= {address[XLEN-1:2], 2'b00};
                busWdata_q <= wdata_n;
                busStrb_q  <= strb_n;
                f3_q       <= funct3;
                lane_q     <= address[1:0];
                cnt_q      <= '0;
            end else if (state_q == S_REQ) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (req_end) begin
                busReq_q <= 1'b0;
                if (!draining) begin
                    readData_q <= end_err ? '0 : load_ext;
                end
            end
        end
    end

    assign stall      = stall_c & ~rst;
    assign misaligned = mis_c & ~rst;
    assign busReq     = busReq_q;
    assign busWe      = busWe_q;
    assign busAddr    = busAddr_q;
    assign busWdata   = busWdata_q;
    assign busStrb    = busStrb_q;
    assign readData   = readData_q;
    assign busError   = busError_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits directly downstream of the datapath, between the core's data-memory port and a handshaked data bus. It takes the core's memory access (ALU result as address, write data, funct3, memRead/memWrite), runs a bus transaction with byte strobes, and returns sign- or zero-extended load data. It stalls the single-cycle core until the access completes, and flags misaligned accesses and bus errors/timeouts.

## Interface
- XLEN, 32: data/address width (only 32 supported).
- TIMEOUT_CYCLES, 256: maximum cycles in REQ without busAck before abort (≥2).
- clk  in  1  clock; rising edge.
- rst  in  1  asynchronous, active-high reset.
- memRead  in  1  core requests a load.
- memWrite  in  1  core requests a store; has priority if both are high.
- funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000 SB, 001 SH, 010 SW.
- address  in  XLEN  byte address (ALU result).
- writeData  in  XLEN  store data, right-aligned.
- readData  out  XLEN  extended load data, valid in DONE.
- stall  out  1  core must hold PC and all inputs stable.
- misaligned  out  1  combinational alignment fault; no bus access is made.
- busError  out  1  one-cycle pulse: bus error or timeout.
- busReq  out  1  bus request; held until busAck.
- busWe  out  1  1 = write.
- busAddr  out  XLEN  word-aligned address ({address[31:2],2'b00}).
- busWdata  out  XLEN  lane-positioned write data.
- busStrb  out  4  byte enables.
- busAck  in  1  transaction complete.
- busRdata  in  XLEN  read word, valid with busAck.
- busErr  in  1  error, sampled only with busAck.

## Operation
- States: IDLE, REQ, DONE.
- IDLE: access = memRead|memWrite. If access and aligned, latch bus outputs, stall=1, go to REQ. If misaligned, misaligned=1, stall=0, stay in IDLE.
- Alignment: halfword requires address[0]=0; word requires address[1:0]=0. Bytes are always aligned. funct3 011/11x is treated as LW/SW.
- REQ: busReq=1 with stable address, data, and strobes; stall=1. On busAck, capture busRdata, go to DONE; busErr=1 with ack sets busError in DONE. If the counter reaches TIMEOUT_CYCLES-1 without ack, drop busReq, go to DONE, and set busError.
- DONE: stall=0 and busReq=0; the core advances at this edge. Always go to IDLE next.
- Store lanes: SB gives strb=1<<address[1:0] and wdata = the byte replicated ×4. SH gives strb 0011/1100 and the halfword replicated ×2. SW gives strb 1111.
- Load extraction: select the lane by address[1:0]. LB/LH sign-extend; LBU/LHU zero-extend. On error or timeout, readData=0.
- Timeout counter: resets to 0 on entry to REQ; increments each REQ cycle.

## Timing
- Reset (async): state IDLE, busReq=0, busWe=0, busAddr=0, busWdata=0, busStrb=0, readData=0, counter=0, busError=0. stall and misaligned are forced to 0 while rst=1.
- Load/blocking store with ack in the first REQ cycle: cycle 0 IDLE (stall), cycle 1 REQ (stall, ack), cycle 2 DONE. This gives two stall cycles; each extra wait cycle adds one.
- Bus outputs are registered and change only on entry to REQ or exit from REQ.
- Ack arriving in the same cycle as the timeout expiry: the ack wins, with no busError.
- rst asserted mid-REQ: busReq drops immediately (async) and the transaction is abandoned.

## Configuration
- LSU_STORE_BUFFER_EN: when defined, adds a one-entry store buffer.
  - An aligned store in IDLE with the buffer empty is captured in one cycle with stall=0. The buffer drains over the bus in the background (busReq from the next cycle).
  - Any access while the buffer is non-empty stalls until the drain's busAck. After that, normal handling resumes.
  - Drain errors or timeouts pulse busError in the completion cycle (imprecise).
- Undefined: stores block exactly like loads (IDLE→REQ→DONE).

## Test plan
- LW at 0x100, busRdata=0xDEADBEEF, ack in the first REQ cycle → busAddr=0x100, strb 0000, busWe=0; stall high 2 cycles; readData=0xDEADBEEF in DONE.
- LB at 0x103 and LBU at 0x103, busRdata=0x80FFFFFF → LB gives 0xFFFFFF80; LBU gives 0x00000080.
- SH at 0x202, writeData=0x1234ABCD → busAddr=0x200, busStrb=1100, busWdata=0xABCDABCD, busWe=1.
- LW at 0x101 → misaligned=1, stall=0, busReq never asserted.
- Load with no ack for TIMEOUT_CYCLES=4 → busReq high for 4 cycles, then drops; DONE with busError=1, readData=0. Separately, ack with busErr=1 → busError pulse.
- rst pulsed during REQ → busReq=0 immediately; next access starts cleanly from IDLE.
- With LSU_STORE_BUFFER_EN: SW followed immediately by LW, store ack delayed 3 cycles → SW stall=0; LW stalls until drain completes, then executes normally.
